mult_share_arbiter: RTL and testbench



---
 rtl/mult_share_arbiter.sv | 156 +++++++++++++++
 tb/tb_mult_share_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one registered OPW x OPW unsigned multiplier among NUM_REQ ports.
// Optional saturating response counter on op_count, enabled by `define MULT_ARB_OPCNT_EN.
module mult_share_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned OPW     = 4,
  parameter int unsigned IDW     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*OPW-1:0] req_a,
  input  logic [NUM_REQ*OPW-1:0] req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [2*OPW-1:0]       rsp_product
`ifdef MULT_ARB_OPCNT_EN
  ,
  output logic [15:0]            op_count
`endif
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e             state_q, state_d;
  logic [OPW-1:0]     a_q, a_d;
  logic [OPW-1:0]     b_q, b_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [IDW-1:0]     last_grant_q, last_grant_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]     rsp_id_q, rsp_id_d;
  logic [2*OPW-1:0]   rsp_product_q, rsp_product_d;

  logic               win_found;
  logic [IDW-1:0]     win_id;
  int                 idx;
  logic               rsp_hs;

  assign rsp_hs = rsp_valid_q && rsp_ready;

  // Scan upward from the requester after the last grant, wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      idx = (int'(last_grant_q) + k) % int'(NUM_REQ);
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = IDW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (win_found) state_d = StCalc;
      StCalc: state_d = StDone;
      StDone: if (rsp_hs) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Grant strobe is combinational and forced low while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (!rst && state_q == StIdle && win_found) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        req_ready[i] = (win_id == IDW'(i));
      end
    end
  end

  always_comb begin
    a_d           = a_q;
    b_d           = b_q;
    id_d          = id_q;
    last_grant_d  = last_grant_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_id_d      = rsp_id_q;
    rsp_product_d = rsp_product_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          a_d          = req_a[win_id*OPW +: OPW];
          b_d          = req_b[win_id*OPW +: OPW];
          id_d         = win_id;
          last_grant_d = win_id;
        end
      end
      StCalc: begin
        rsp_product_d = {{OPW{1'b0}}, a_q} * {{OPW{1'b0}}, b_q};
        rsp_id_d      = id_q;
        rsp_valid_d   = 1'b1;
      end
      StDone: begin
        if (rsp_hs) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q           <= '0;
      b_q           <= '0;
      id_q          <= '0;
      last_grant_q  <= IDW'(NUM_REQ - 1);
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_product_q <= '0;
    end else begin
      a_q           <= a_d;
      b_q           <= b_d;
      id_q          <= id_d;
      last_grant_q  <= last_grant_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_product_q <= rsp_product_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_product = rsp_product_q;

`ifdef MULT_ARB_OPCNT_EN
  logic [15:0] op_count_q, op_count_d;

  always_comb begin
    op_count_d = op_count_q;
    if (rsp_hs && op_count_q != 16'hFFFF) op_count_d = op_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count_q <= '0;
    end else begin
      op_count_q <= op_count_d;
    end
  end

  assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_mult_share_arbiter;

  localparam int N = 4;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_product;
`ifdef MULT_ARB_OPCNT_EN
  logic [15:0] op_count;
`endif

  int tests;
  int fails;

  mult_share_arbiter #(.NUM_REQ(4), .OPW(4), .IDW(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product)
`ifdef MULT_ARB_OPCNT_EN
    ,
    .op_count    (op_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    next();
    next();
    rst = 1'b0;
    #1;
  endtask

  // Reference arbitration: first pending requester after 'last', wrapping.
  function automatic int rr_pick(input int last, input logic [3:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic test_reset;
    rst       = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    req_a     = 16'hFFFF;
    req_b     = 16'hFFFF;
    next();
    tests++;
    if (req_ready !== 4'b0000) begin
      fails++; $display("FAIL reset_req_ready: got %b want 0000", req_ready);
    end
    tests++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_product !== 8'd0) begin
      fails++;
      $display("FAIL reset_outputs: got v=%b id=%0d p=%0d want 0/0/0", rsp_valid, rsp_id,
               rsp_product);
    end
    rst       = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    #1;
  endtask

  task automatic test_single;
    reset_dut();
    req_valid    = 4'b0001;
    req_a[3:0]   = 4'd15;
    req_b[3:0]   = 4'd15;
    rsp_ready    = 1'b1;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin
      fails++; $display("FAIL single_grant: got %b want 0001", req_ready);
    end
    next();
    req_valid = '0;
    #1;
    tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
      fails++; $display("FAIL single_calc: got v=%b rdy=%b want 0/0000", rsp_valid, req_ready);
    end
    next();
    tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_product !== 8'd225) begin
      fails++;
      $display("FAIL single_rsp: got v=%b id=%0d p=%0d want 1/0/225", rsp_valid, rsp_id,
               rsp_product);
    end
    next();
    tests++;
    if (rsp_valid !== 1'b0) begin
      fails++; $display("FAIL single_idle: got v=%b want 0", rsp_valid);
    end
    req_valid = 4'b0010;
    #1;
    tests++;
    if (req_ready !== 4'b0010) begin
      fails++; $display("FAIL single_back_idle: got %b want 0010", req_ready);
    end
    req_valid = '0;
    #1;
  endtask

  task automatic test_round_robin;
    int gid[5];
    int gcyc[5];
    int prod[5];
    int ng;
    int np;
    int exp_id[5];
    exp_id = '{0, 1, 2, 3, 0};
    ng = 0;
    np = 0;
    reset_dut();
    for (int i = 0; i < N; i++) begin
      req_a[i*4 +: 4] = 4'(i + 1);
      req_b[i*4 +: 4] = 4'd3;
    end
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    for (int cyc = 0; cyc < 40 && (ng < 5 || np < 5); cyc++) begin
      if (req_ready != 4'b0000 && ng < 5) begin
        for (int i = 0; i < N; i++) if (req_ready[i]) gid[ng] = i;
        gcyc[ng] = cyc;
        ng++;
      end
      if (rsp_valid && rsp_ready && np < 5) begin
        prod[np] = int'(rsp_product);
        np++;
      end
      next();
    end
    req_valid = '0;
    tests++;
    if (ng != 5 || np != 5) begin
      fails++; $display("FAIL rr_timeout: got grants=%0d rsps=%0d want 5/5", ng, np);
    end else begin
      for (int j = 0; j < 5; j++) begin
        tests++;
        if (gid[j] != exp_id[j] || prod[j] != (exp_id[j] + 1) * 3) begin
          fails++;
          $display("FAIL rr_order[%0d]: got id=%0d p=%0d want id=%0d p=%0d", j, gid[j],
                   prod[j], exp_id[j], (exp_id[j] + 1) * 3);
        end
        if (j > 0) begin
          tests++;
          if (gcyc[j] - gcyc[j-1] != 3) begin
            fails++;
            $display("FAIL rr_spacing[%0d]: got %0d want 3", j, gcyc[j] - gcyc[j-1]);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure;
    reset_dut();
    req_valid  = 4'b0001;
    req_a[3:0] = 4'd7;
    req_b[3:0] = 4'd9;
    rsp_ready  = 1'b0;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin
      fails++; $display("FAIL bp_grant: got %b want 0001", req_ready);
    end
    next();
    req_valid = '0;
    next();
    for (int c = 0; c < 5; c++) begin
      req_valid = 4'b0011;
      req_a     = 16'hFFFF;
      #1;
      tests++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_product !== 8'd63
          || req_ready !== 4'b0000) begin
        fails++;
        $display("FAIL bp_hold[%0d]: got v=%b id=%0d p=%0d rdy=%b want 1/0/63/0000", c,
                 rsp_valid, rsp_id, rsp_product, req_ready);
      end
      next();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    #1;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_product !== 8'd63) begin
      fails++; $display("FAIL bp_last: got v=%b p=%0d want 1/63", rsp_valid, rsp_product);
    end
    next();
    tests++;
    if (rsp_valid !== 1'b0) begin
      fails++; $display("FAIL bp_handshake: got v=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_reset_mid_op;
    reset_dut();
    req_valid   = 4'b0100;
    req_a[11:8] = 4'd5;
    req_b[11:8] = 4'd5;
    rsp_ready   = 1'b1;
    next();
    req_valid = '0;
    rst       = 1'b1;
    #1;
    tests++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_product !== 8'd0
        || req_ready !== 4'b0000) begin
      fails++;
      $display("FAIL midrst_outputs: got v=%b id=%0d p=%0d rdy=%b want 0/0/0/0000",
               rsp_valid, rsp_id, rsp_product, req_ready);
    end
    next();
    next();
    rst = 1'b0;
    next();
    tests++;
    if (rsp_valid !== 1'b0 || rsp_product !== 8'd0) begin
      fails++; $display("FAIL midrst_no_rsp: got v=%b p=%0d want 0/0", rsp_valid, rsp_product);
    end
    req_valid = 4'b1111;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin
      fails++; $display("FAIL midrst_priority: got %b want 0001", req_ready);
    end
    req_valid = '0;
    #1;
  endtask

  task automatic test_operand_change;
    reset_dut();
    req_valid   = 4'b0100;
    req_a[11:8] = 4'd3;
    req_b[11:8] = 4'd4;
    rsp_ready   = 1'b1;
    #1;
    tests++;
    if (req_ready !== 4'b0100) begin
      fails++; $display("FAIL opchg_grant: got %b want 0100", req_ready);
    end
    next();
    req_valid = '0;
    req_a     = 16'h9999;
    next();
    tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_product !== 8'd12) begin
      fails++;
      $display("FAIL opchg_rsp: got v=%b id=%0d p=%0d want 1/2/12", rsp_valid, rsp_id,
               rsp_product);
    end
    next();
  endtask

  // Transaction model: a grant produces a response two cycles later, held until accepted.
  task automatic test_random;
    int m_last;
    int m_phase;
    int m_id;
    int m_prod;
    int w;
    int bad;
    logic [3:0] exp_rdy;
    reset_dut();
    m_last  = N - 1;
    m_phase = 0;
    m_id    = 0;
    m_prod  = 0;
    bad     = 0;
    for (int c = 0; c < 400; c++) begin
      req_valid = 4'($urandom_range(0, 15));
      req_a     = 16'($urandom);
      req_b     = 16'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      w = rr_pick(m_last, req_valid);
      exp_rdy = '0;
      if (m_phase == 0 && w >= 0) exp_rdy[w] = 1'b1;
      tests++;
      if (req_ready !== exp_rdy || rsp_valid !== (m_phase == 2)) begin
        fails++;
        if (bad < 10)
          $display("FAIL rand_ctrl[%0d]: got rdy=%b v=%b want rdy=%b v=%b", c, req_ready,
                   rsp_valid, exp_rdy, (m_phase == 2));
        bad++;
      end
      if (m_phase == 2) begin
        tests++;
        if (int'(rsp_id) != m_id || int'(rsp_product) != m_prod) begin
          fails++;
          if (bad < 10)
            $display("FAIL rand_data[%0d]: got id=%0d p=%0d want id=%0d p=%0d", c, rsp_id,
                     rsp_product, m_id, m_prod);
          bad++;
        end
      end
      if (m_phase == 0 && w >= 0) begin
        m_last  = w;
        m_id    = w;
        m_prod  = int'(req_a[w*4 +: 4]) * int'(req_b[w*4 +: 4]);
        m_phase = 1;
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else if (m_phase == 2 && rsp_ready) begin
        m_phase = 0;
      end
      next();
    end
    req_valid = '0;
  endtask

`ifdef MULT_ARB_OPCNT_EN
  task automatic run_op(input int id, input logic [3:0] a, input logic [3:0] b);
    req_valid           = '0;
    req_valid[id]       = 1'b1;
    req_a[id*4 +: 4]    = a;
    req_b[id*4 +: 4]    = b;
    rsp_ready           = 1'b1;
    next();
    req_valid = '0;
    next();
    next();
  endtask

  task automatic test_opcount;
    reset_dut();
    tests++;
    if (op_count !== 16'd0) begin
      fails++; $display("FAIL opcnt_reset: got %0d want 0", op_count);
    end
    run_op(1, 4'd2, 4'd3);
    run_op(2, 4'd4, 4'd5);
    run_op(3, 4'd6, 4'd7);
    tests++;
    if (op_count !== 16'd3) begin
      fails++; $display("FAIL opcnt_three: got %0d want 3", op_count);
    end
    force dut.op_count_q = 16'hFFFF;
    #1;
    release dut.op_count_q;
    run_op(0, 4'd1, 4'd1);
    tests++;
    if (op_count !== 16'hFFFF) begin
      fails++; $display("FAIL opcnt_saturate: got %h want ffff", op_count);
    end
  endtask
`endif

  initial begin
    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid_op();
    test_operand_change();
    test_random();
`ifdef MULT_ARB_OPCNT_EN
    test_opcount();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
